apple_spawn_ctrl: RTL and testbench

APPLE_SPAWN_CTRL -- requirements
Module: apple_spawn_ctrl

---
 rtl/apple_spawn_ctrl.sv | 176 +++++++++++++++++
 tb/tb_apple_spawn_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_spawn_ctrl.sv
// apple_spawn_ctrl: picks a random apple cell that is not on the snake body.
// It draws a candidate, scans the body one segment per cycle and redraws on a
// hit. It then commits the position and pulses `placed`.
// Optional feature macro: APPLE_RETRY_LIMIT_EN adds a 4-bit retry counter.
// With the macro defined, 16 consecutive rejections abandon the request and
// pulse `no_space`.
module apple_spawn_ctrl #(
    parameter int unsigned MAX_LEN = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 goodColl,
    input  logic [3:0]           randX,
    input  logic [3:0]           randY,
    input  logic [8*MAX_LEN-1:0] body,
    input  logic [5:0]           length,
    output logic [3:0]           apple_x,
    output logic [3:0]           apple_y,
    output logic                 apple_valid,
    output logic                 placed,
    output logic                 busy
`ifdef APPLE_RETRY_LIMIT_EN
    ,
    output logic                 no_space
`endif
);

    typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, COMMIT} state_t;

    localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] cand_q, cand_d;
    logic [5:0] len_q, len_d;
    logic [5:0] idx_q, idx_d;
    logic [3:0] ax_q, ax_d;
    logic [3:0] ay_q, ay_d;
    logic       valid_q, valid_d;
    logic       pending_q, pending_d;
    logic [5:0] len_clamped;
    logic [7:0] seg;
`ifdef APPLE_RETRY_LIMIT_EN
    logic [3:0] retry_q, retry_d;
    logic       no_space_q, no_space_d;
`endif

    assign len_clamped = (length > MAX_LEN6) ? MAX_LEN6 : length;

    // Select the body segment addressed by the scan index
    always_comb begin
        seg = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 6'(i)) seg = body[8*i +: 8];
        end
    end

    // Next-state logic: placement sequencing, request merging, retry tracking
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        len_d     = len_q;
        idx_d     = idx_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        valid_d   = valid_q;
        pending_d = pending_q | (goodColl && (state_q != IDLE));
`ifdef APPLE_RETRY_LIMIT_EN
        retry_d    = retry_q;
        no_space_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (goodColl) begin
                    state_d = SAMPLE;
`ifdef APPLE_RETRY_LIMIT_EN
                    retry_d = '0;
`endif
                end
            end
            SAMPLE: begin
                cand_d  = {randX, randY};
                len_d   = len_clamped;
                idx_d   = '0;
                valid_d = 1'b0;
                if (len_clamped == '0) begin
                    // Empty body: commit the freshly drawn candidate directly.
                    state_d = COMMIT;
                    ax_d    = randX;
                    ay_d    = randY;
                    valid_d = 1'b1;
                end else begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (seg == cand_q) begin
`ifdef APPLE_RETRY_LIMIT_EN
                    if (retry_q == 4'hF) begin
                        // Board considered full: drop this and any queued request.
                        state_d    = IDLE;
                        no_space_d = 1'b1;
                        pending_d  = 1'b0;
                        retry_d    = '0;
                    end else begin
                        state_d = SAMPLE;
                        retry_d = retry_q + 4'd1;
                    end
`else
                    state_d = SAMPLE;
`endif
                end else if (idx_q == len_q - 6'd1) begin
                    state_d = COMMIT;
                    ax_d    = cand_q[7:4];
                    ay_d    = cand_q[3:0];
                    valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            COMMIT: begin
`ifdef APPLE_RETRY_LIMIT_EN
                retry_d = '0;
`endif
                // A strobe arriving in this very cycle is folded into the pending request.
                if (pending_q || goodColl) begin
                    state_d   = SAMPLE;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset restarts with an automatic placement
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SAMPLE;
            cand_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
`ifdef APPLE_RETRY_LIMIT_EN
            retry_q    <= '0;
            no_space_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
`ifdef APPLE_RETRY_LIMIT_EN
            retry_q    <= retry_d;
            no_space_q <= no_space_d;
`endif
        end
    end

    assign apple_x     = ax_q;
    assign apple_y     = ay_q;
    assign apple_valid = valid_q;
    assign placed      = (state_q == COMMIT);
    assign busy        = (state_q != IDLE);
`ifdef APPLE_RETRY_LIMIT_EN
    assign no_space    = no_space_q;
`endif

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Self-checking bench for apple_spawn_ctrl.
// The reference model works per transaction. For each draw it searches the
// body for the first matching cell and advances time by the cycles that scan
// costs. From that it predicts the commit cycle and the committed position.
module tb_apple_spawn_ctrl;
    localparam int ML = 50;
    localparam int RN = 20000;

    logic          clk = 1'b0;
    logic          reset;
    logic          goodColl;
    logic [3:0]    randX, randY;
    logic [8*ML-1:0] body;
    logic [5:0]    length;
    logic [3:0]    apple_x, apple_y;
    logic          apple_valid, placed, busy;
`ifdef APPLE_RETRY_LIMIT_EN
    logic          no_space;
`endif

    apple_spawn_ctrl #(.MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset), .goodColl(goodColl),
        .randX(randX), .randY(randY), .body(body), .length(length),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .placed(placed), .busy(busy)
`ifdef APPLE_RETRY_LIMIT_EN
        , .no_space(no_space)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] rnd [RN];
    logic [7:0] segs [ML];
    logic [7:0] last_ap = 8'h00;

    initial begin
        #900_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; drive this cycle's random candidate.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        randX = rnd[cyc % RN][7:4];
        randY = rnd[cyc % RN][3:0];
    endtask

    function automatic int eff_len();
        return (int'(length) > ML) ? ML : int'(length);
    endfunction

    task automatic load_body();
        for (int i = 0; i < ML; i++) body[8*i +: 8] = segs[i];
    endtask

    // Bias upcoming draws toward body cells so collisions actually happen.
    task automatic gen_rnd(input int n);
        int L;
        L = eff_len();
        for (int k = 1; k <= n; k++) begin
            if (L > 0 && ($urandom % 3) == 0)
                rnd[(cyc + k) % RN] = segs[$urandom_range(0, L - 1)];
            else
                rnd[(cyc + k) % RN] = 8'($urandom);
        end
    endtask

    // Predicts the commit cycle for a request whose first SAMPLE is at cycle t0.
    function automatic void model_place(input int t0, output int tc, output logic [7:0] ap);
        int t, L, hit;
        logic [7:0] cand;
        t = t0; L = eff_len(); tc = -1; ap = '0;
        for (int it = 0; it < 2000; it++) begin
            cand = rnd[t % RN];
            hit = -1;
            for (int j = 0; j < L; j++) begin
                if (hit < 0 && segs[j] == cand) hit = j;
            end
            if (hit < 0) begin
                tc = t + 1 + L;
                ap = cand;
                return;
            end
            t = t + 2 + hit;
        end
    endfunction

    // Checks a placement cycle by cycle, from SAMPLE at t0 through COMMIT.
    task automatic check_window(input int t0, input int g1, input int g2, output int tc);
        logic [7:0] ap;
        model_place(t0, tc, ap);
        if (tc < 0 || tc - t0 > 5000) begin
            chk("model_budget", 32'(tc), 32'(t0 + 1));
            tc = cyc;
            return;
        end
        while (cyc <= tc) begin
            goodColl = (cyc == g1) || (cyc == g2);
            chk("busy", busy, 1);
            chk("placed", placed, 32'(cyc == tc));
            if (cyc > t0 && cyc < tc) chk("valid_low", apple_valid, 0);
            if (cyc == tc) begin
                chk("apple_x", apple_x, ap[7:4]);
                chk("apple_y", apple_y, ap[3:0]);
                chk("valid_set", apple_valid, 1);
            end
            step();
        end
        goodColl = 1'b0;
        last_ap = ap;
    endtask

    task automatic idle_check();
        chk("idle_busy", busy, 0);
        chk("idle_placed", placed, 0);
        chk("idle_valid", apple_valid, 1);
        chk("idle_apple", {apple_x, apple_y}, last_ap);
    endtask

    task automatic request(output int t0);
        goodColl = 1'b1;
        step();
        goodColl = 1'b0;
        t0 = cyc;
    endtask

    int t0, tc, tc2, tpeek;
    logic [7:0] appeek;

    initial begin
        for (int k = 0; k < RN; k++) rnd[k] = 8'($urandom);
        for (int i = 0; i < ML; i++) segs[i] = 8'($urandom);
        segs[0] = 8'h11; segs[1] = 8'h12; segs[2] = 8'h13;
        load_body();
        length = 6'd3;
        reset = 1'b1;
        goodColl = 1'b1;
        rnd[2] = 8'h55;
        randX = rnd[0][7:4];
        randY = rnd[0][3:0];

        // Reset values; goodColl held high during reset must be ignored
        step(); step();
        chk("rst_placed", placed, 0);
        chk("rst_apple", {apple_x, apple_y}, 0);
        chk("rst_valid", apple_valid, 0);
        chk("rst_busy", busy, 1);
        reset = 1'b0;
        goodColl = 1'b0;

        // Automatic first placement after reset, (5,5) beside a 3-segment body
        t0 = cyc;
        check_window(t0, -1, -1, tc);
        chk("first_latency", 32'(tc - t0), 4);
        idle_check();

        // One retry: first draw lands on (1,2), second is (7,7)
        rnd[(cyc + 1) % RN] = 8'h12;
        rnd[(cyc + 4) % RN] = 8'h77;
        request(t0);
        check_window(t0, -1, -1, tc);
        chk("retry_apple", last_ap, 8'h77);
        idle_check();

        // Two strobes while busy merge into one extra placement
        gen_rnd(400);
        request(t0);
        check_window(t0, t0 + 1, t0 + 2, tc);
        check_window(cyc, -1, -1, tc2);
        idle_check();

        // Empty body commits straight after SAMPLE
        length = 6'd0;
        gen_rnd(50);
        request(t0);
        check_window(t0, -1, -1, tc);
        chk("len0_latency", 32'(tc - t0), 1);
        idle_check();

        // Over-long length is clamped to MAX_LEN scans
        length = 6'd63;
        for (int i = 0; i < ML; i++) segs[i] = {4'h0, 4'(i % 16)};
        for (int i = 16; i < ML; i++) segs[i] = {4'(1 + i / 16), 4'(i % 16)};
        load_body();
        rnd[(cyc + 1) % RN] = 8'hEE;
        request(t0);
        check_window(t0, -1, -1, tc);
        chk("clamp_latency", 32'(tc - t0), 51);
        idle_check();

        // Randomized placements with random bodies and lengths
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < ML; i++) segs[i] = 8'($urandom);
            load_body();
            length = (($urandom % 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 8));
            gen_rnd(1500);
            for (int w = $urandom_range(0, 3); w > 0; w--) begin
                chk("rand_idle_busy", busy, 0);
                step();
            end
            request(t0);
            model_place(t0, tpeek, appeek);
            if (($urandom % 2) == 0 && tpeek > t0 + 1) begin
                check_window(t0, t0 + 1, -1, tc);
                check_window(cyc, -1, -1, tc2);
            end else begin
                check_window(t0, -1, -1, tc);
            end
            idle_check();
        end

        // Reset in the middle of a scan restarts placement from reset values
        for (int i = 0; i < ML; i++) segs[i] = 8'($urandom);
        load_body();
        length = 6'd10;
        gen_rnd(400);
        request(t0);
        step(); step(); step();
        reset = 1'b1;
        goodColl = 1'b1;
        step();
        reset = 1'b0;
        goodColl = 1'b0;
        chk("midrst_placed", placed, 0);
        chk("midrst_apple", {apple_x, apple_y}, 0);
        chk("midrst_valid", apple_valid, 0);
        chk("midrst_busy", busy, 1);
        t0 = cyc;
        check_window(t0, -1, -1, tc);
        idle_check();

`ifdef APPLE_RETRY_LIMIT_EN
        // Every draw hits segment 0: 16 rejections then give up
        for (int k = 1; k <= 60; k++) rnd[(cyc + k) % RN] = segs[0];
        request(t0);
        for (int k = 0; k < 40; k++) begin
            chk("nospace_pulse", no_space, 32'(cyc == t0 + 32));
            chk("nospace_busy", busy, 32'(cyc < t0 + 32));
            chk("nospace_placed", placed, 0);
            if (cyc > t0) chk("nospace_valid", apple_valid, 0);
            step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
